// File: rtl/hh_pkg.sv
// Shared constants and types for the Hodgkin-Huxley gate sequencer.
package hh_pkg;

  // Q9.5 unsigned data path
  localparam int WIDTH    = 14;
  localparam int FRAC     = 5;
  localparam int ONE      = 1 << FRAC;
  localparam int DT_SHIFT = 3;

  // Signed accumulator width; wide enough that acc - (beta*x >> FRAC) never overflows
  localparam int ACC_W    = 25;

  // Reset values of the gates (Q9.5)
  localparam int N_INIT   = 10;
  localparam int M_INIT   = 2;
  localparam int H_INIT   = 19;

  // Gate index encoding
  localparam logic [1:0] GATE_N = 2'd0;
  localparam logic [1:0] GATE_M = 2'd1;
  localparam logic [1:0] GATE_H = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MUL_A,
    S_MUL_B,
    S_DONE
  } state_t;

endpackage

// File: rtl/hh_euler_mac.sv
// Shared multiply/subtract unit for one forward-Euler gate update.
// Phase A (i_mul_b = 0): next acc = (rate * (ONE - x)) >> FRAC.
// Phase B (i_mul_b = 1): next x = clamp(x + ((acc - (rate * x >> FRAC)) >>> DT_SHIFT), 0, ONE).
module hh_euler_mac
  import hh_pkg::*;
#(
  parameter int WIDTH    = hh_pkg::WIDTH,
  parameter int FRAC     = hh_pkg::FRAC,
  parameter int DT_SHIFT = hh_pkg::DT_SHIFT
) (
  input  logic                    i_mul_b,
  input  logic [WIDTH-1:0]        i_rate,
  input  logic [WIDTH-1:0]        i_x,
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [ACC_W-1:0] o_acc_next,
  output logic [WIDTH-1:0]        o_x_next
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0]        ONE_W   = WIDTH'(1 << FRAC);
  localparam logic signed [ACC_W-1:0] ONE_ACC = ACC_W'(1 << FRAC);

  logic [WIDTH-1:0]        w_opb;
  logic [PW-1:0]           w_prod;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_d;
  logic signed [ACC_W-1:0] w_step;
  logic signed [ACC_W-1:0] w_sum;

  // Second operand: the closing fraction (ONE - x) for alpha, the gate itself for beta
  assign w_opb  = i_mul_b ? i_x : (ONE_W - i_x);
  assign w_prod = PW'(i_rate) * PW'(w_opb);
  assign w_term = $signed(ACC_W'(w_prod >> FRAC));

  assign o_acc_next = w_term;
  assign w_d        = i_acc - w_term;
  assign w_step     = w_d >>> DT_SHIFT;
  assign w_sum      = $signed({{(ACC_W-WIDTH){1'b0}}, i_x}) + w_step;

  // Keep the gate inside [0, ONE] so (ONE - x) stays non-negative next step
  always_comb begin
    o_x_next = WIDTH'(w_sum);
    if (w_sum[ACC_W-1]) begin
      o_x_next = '0;
    end else if (w_sum > ONE_ACC) begin
      o_x_next = ONE_W;
    end
  end

endmodule

// File: rtl/hh_gate_sequencer.sv
// Sequences one forward-Euler step of the n, m, h gates per start request.
// Latches the voltage for the rate evaluator, waits for the rates to settle,
// then updates n, m, h in turn through one shared multiply/subtract unit.
module hh_gate_sequencer
  import hh_pkg::*;
#(
  parameter int WIDTH         = hh_pkg::WIDTH,
  parameter int FRAC          = hh_pkg::FRAC,
  parameter int DT_SHIFT      = hh_pkg::DT_SHIFT,
  parameter int SETTLE_CYCLES = 2,
  parameter int N_INIT        = hh_pkg::N_INIT,
  parameter int M_INIT        = hh_pkg::M_INIT,
  parameter int H_INIT        = hh_pkg::H_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] voltage,
  output logic [WIDTH-1:0] v_to_rate,
  input  logic [WIDTH-1:0] alpha_n,
  input  logic [WIDTH-1:0] alpha_m,
  input  logic [WIDTH-1:0] alpha_h,
  input  logic [WIDTH-1:0] beta_n,
  input  logic [WIDTH-1:0] beta_m,
  input  logic [WIDTH-1:0] beta_h,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] n_out,
  output logic [WIDTH-1:0] m_out,
  output logic [WIDTH-1:0] h_out
);

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [1:0]              r_g;
  logic signed [ACC_W-1:0] r_acc;
  logic [WIDTH-1:0]        r_v;
  logic [WIDTH-1:0]        r_n;
  logic [WIDTH-1:0]        r_m;
  logic [WIDTH-1:0]        r_h;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_mul_b;
  logic [WIDTH-1:0]        w_rate;
  logic [WIDTH-1:0]        w_x;
  logic [WIDTH-1:0]        w_x_next;
  logic signed [ACC_W-1:0] w_acc_next;

  assign w_mul_b = (r_state == S_MUL_B);

  // Route the selected gate and its alpha (phase A) or beta (phase B) to the shared unit
  always_comb begin
    w_x    = r_n;
    w_rate = w_mul_b ? beta_n : alpha_n;
    case (r_g)
      GATE_M: begin
        w_x    = r_m;
        w_rate = w_mul_b ? beta_m : alpha_m;
      end
      GATE_H: begin
        w_x    = r_h;
        w_rate = w_mul_b ? beta_h : alpha_h;
      end
      default: ;
    endcase
  end

  hh_euler_mac #(
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .DT_SHIFT (DT_SHIFT)
  ) u_mac (
    .i_mul_b    (w_mul_b),
    .i_rate     (w_rate),
    .i_x        (w_x),
    .i_acc      (r_acc),
    .o_acc_next (w_acc_next),
    .o_x_next   (w_x_next)
  );

  // Step FSM with registered busy/done; reset mid-step restores the gates and drops the step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_g     <= GATE_N;
      r_acc   <= '0;
      r_v     <= '0;
      r_n     <= WIDTH'(N_INIT);
      r_m     <= WIDTH'(M_INIT);
      r_h     <= WIDTH'(H_INIT);
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_v     <= voltage;
            r_cnt   <= 4'(SETTLE_CYCLES - 1);
            r_g     <= GATE_N;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_MUL_A;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_MUL_A: begin
          r_acc   <= w_acc_next;
          r_state <= S_MUL_B;
        end
        S_MUL_B: begin
          case (r_g)
            GATE_N:  r_n <= w_x_next;
            GATE_M:  r_m <= w_x_next;
            default: r_h <= w_x_next;
          endcase
          if (r_g < GATE_H) begin
            r_g     <= r_g + 2'd1;
            r_state <= S_MUL_A;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign v_to_rate = r_v;
  assign busy      = r_busy;
  assign done      = r_done;
  assign n_out     = r_n;
  assign m_out     = r_m;
  assign h_out     = r_h;

endmodule
